// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
// Scans a 4x4 active-low matrix keypad one column at a time. Each column is
// driven for SCAN_DIV cycles and its synchronized rows are sampled on the
// divider tick. A full frame is committed to key_n after column 3.
// Derived outputs: any_key, key_code (lowest pressed index) and a
// frame_done strobe.
//
// Optional build macro: KEYPAD_GHOST_BLOCK_EN
//   If defined, a candidate frame with 3 or more pressed keys is not
//   committed, and ghost is flagged until the next commit.
//   If undefined, every frame commits and ghost is tied to 0.
//
// state | meaning
// COL0  | column 0 driven low, rows sampled into frame_buf[3:0]
// COL1  | column 1 driven low, rows sampled into frame_buf[7:4]
// COL2  | column 2 driven low, rows sampled into frame_buf[11:8]
// COL3  | column 3 driven low, rows + frame_buf committed to key_n

module keypad_matrix_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] key_n,
  output logic        any_key,
  output logic [3:0]  key_code,
  output logic        frame_done,
  output logic        ghost
);

  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [3:0]       row_s1;
  logic [3:0]       row_s;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_nxt;
  logic [15:0]      frame_buf;
  logic             tick;
  logic             commit;
  logic [15:0]      cand;
  logic [3:0]       cand_code;

  // A tick only counts while scanning, so a falling scan_en always wins.
  assign tick   = scan_en && (cnt == CNT_LAST);
  assign commit = tick && (col_idx == COL3);
  assign cand   = {row_s, frame_buf[11:0]};

  // Next column in the scan order.
  always_comb begin
    col_idx_nxt = COL0;
    case (col_idx)
      COL0:    col_idx_nxt = COL1;
      COL1:    col_idx_nxt = COL2;
      COL2:    col_idx_nxt = COL3;
      COL3:    col_idx_nxt = COL0;
      default: col_idx_nxt = COL0;
    endcase
  end

  // Lowest pressed (zero) bit of the candidate frame; 0 when none pressed.
  always_comb begin
    cand_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!cand[i]) cand_code = 4'(i);
    end
  end

  // Two-flop row synchronizer, free-running regardless of scan_en.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_s1 <= 4'hF;
      row_s  <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s  <= row_s1;
    end
  end

  // Divider, column FSM, column drive and per-column row sampling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      col_idx   <= COL0;
      col       <= 4'b1110;
      frame_buf <= 16'hFFFF;
    end else if (!scan_en) begin
      cnt     <= '0;
      col_idx <= COL0;
      col     <= 4'b1111;
    end else if (tick) begin
      cnt                          <= '0;
      col_idx                      <= col_idx_nxt;
      col                          <= ~(4'b0001 << col_idx_nxt);
      frame_buf[{col_idx, 2'b00} +: 4] <= row_s;
    end else begin
      cnt <= cnt + 1'b1;
      col <= ~(4'b0001 << col_idx);
    end
  end

`ifdef KEYPAD_GHOST_BLOCK_EN
  logic [4:0] zero_cnt;
  logic       ghost_q;

  // Number of pressed keys in the candidate frame.
  always_comb begin
    zero_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      zero_cnt = zero_cnt + {4'd0, ~cand[i]};
    end
  end

  // Frame commit; frames with 3+ pressed keys are held back as ghosted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_n      <= 16'hFFFF;
      any_key    <= 1'b0;
      key_code   <= 4'd0;
      frame_done <= 1'b0;
      ghost_q    <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) begin
        if (zero_cnt >= 5'd3) begin
          ghost_q <= 1'b1;
        end else begin
          key_n    <= cand;
          any_key  <= ~&cand;
          key_code <= cand_code;
          ghost_q  <= 1'b0;
        end
      end
    end
  end

  assign ghost = ghost_q;
`else
  // Frame commit; outputs are derived from the candidate so they align with key_n.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_n      <= 16'hFFFF;
      any_key    <= 1'b0;
      key_code   <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit;
      if (commit) begin
        key_n    <= cand;
        any_key  <= ~&cand;
        key_code <= cand_code;
      end
    end
  end

  assign ghost = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan (SCAN_DIV=4). A behavioural keypad drives the
// rows from the set of held keys; expected outputs come from that key set.
module tb_keypad_matrix_scan;

`ifdef KEYPAD_GHOST_BLOCK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key_n;
  logic        any_key;
  logic [3:0]  key_code;
  logic        frame_done;
  logic        ghost;

  logic [15:0] press = 16'h0000;
  logic [15:0] exp_key = 16'hFFFF;
  logic        exp_ghost = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  keypad_matrix_scan #(.SCAN_DIV(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .row(row), .col(col),
    .key_n(key_n), .any_key(any_key), .key_code(key_code),
    .frame_done(frame_done), .ghost(ghost)
  );

  // Keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && press[c*4+r]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] lowest_pressed(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (!k[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 64);
    chk("frame_timeout", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_key_n"}, {16'd0, key_n}, {16'd0, exp_key});
    chk({tag, "_any_key"}, {31'd0, any_key}, {31'd0, exp_key != 16'hFFFF});
    chk({tag, "_key_code"}, {28'd0, key_code}, {28'd0, lowest_pressed(exp_key)});
    chk({tag, "_ghost"}, {31'd0, ghost}, {31'd0, exp_ghost});
  endtask

  // Change held keys at a frame boundary, let two full frames commit, check.
  task automatic apply_mask(input string tag, input logic [15:0] m);
    wait_frame();
    press = m;
    wait_frame();
    wait_frame();
    if (GHOST_EN && $countones(m) >= 3) begin
      exp_ghost = 1'b1;
    end else begin
      exp_key   = ~m;
      exp_ghost = 1'b0;
    end
    check_outputs(tag);
  endtask

  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (col !== c && n < 64) begin
      step();
      n++;
    end
    chk("col_wait_timeout", {28'd0, col}, {28'd0, c});
  endtask

  initial begin
    logic [15:0] m;
    int n;
    rst = 1'b0;
    scan_en = 1'b1;
    repeat (3) step();
    chk("rst_col", {28'd0, col}, 32'hE);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_outputs("rst");

    rst = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("col_seq", {28'd0, col}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
      chk("frame_period", {31'd0, frame_done}, {31'd0, (k % 16) == 0});
    end
    check_outputs("idle");

    apply_mask("key9", 16'h0200);
    apply_mask("release9", 16'h0000);
    apply_mask("key5_14", 16'h4020);
    apply_mask("key9b", 16'h0200);

    // Halt scanning mid-COL2.
    wait_col(4'b1011);
    step();
    scan_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_col", {28'd0, col}, 32'hF);
      chk("halt_frame_done", {31'd0, frame_done}, 32'd0);
      chk("halt_key_n", {16'd0, key_n}, {16'd0, exp_key});
    end
    scan_en = 1'b1;
    step();
    chk("restart_col", {28'd0, col}, 32'hE);
    n = 1;
    while (!frame_done && n < 64) begin
      step();
      n++;
    end
    chk("restart_latency", n, 16);
    check_outputs("restart");

    // Reset on the would-be commit edge of COL3 with key 0 held.
    apply_mask("key0", 16'h0001);
    wait_col(4'b0111);
    repeat (3) step();
    rst = 1'b0;
    step();
    exp_key = 16'hFFFF;
    exp_ghost = 1'b0;
    chk("midrst_col", {28'd0, col}, 32'hE);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    check_outputs("midrst");
    rst = 1'b1;
    press = 16'h0000;

    apply_mask("keys0_1_4", 16'h0013);
    apply_mask("keys0_1", 16'h0003);

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1: m = 16'(1) << $urandom_range(0, 15);
        2: m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: m = 16'($urandom);
      endcase
      apply_mask("random", m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
- Scans a 4x4 active-low matrix keypad, one column at a time.
- Produces a 16-bit active-low key level vector that feeds the debounce stage's `key` input directly (N=16, idle all-ones).
- Also provides a lowest-pressed-key code and a frame-complete strobe for the game control logic.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven before its rows are sampled (1 ms at 50 MHz); legal range >= 4.
- CNT_W, 16, width of the divider counter; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-low reset.
- scan_en  input  1  1 = scanning; 0 = scanning halted.
- row  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
- col  output  4  keypad column drive, one-cold; 4'b1111 when idle.
- key_n  output  16  key levels, active-low; bit index = col_idx*4 + row_idx.
- any_key  output  1  1 when any bit of key_n is 0.
- key_code  output  4  index of the lowest-numbered 0 bit in key_n; 0 when none is pressed.
- frame_done  output  1  one-cycle pulse when key_n is updated.
- ghost  output  1  ghost-block indication (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst=0 at posedge clk):
  - cnt=0, col_idx=0, col=4'b1110.
  - frame_buf=16'hFFFF, key_n=16'hFFFF.
  - any_key=0, key_code=0, frame_done=0, ghost=0.
  - Row synchronizer flops = 4'b1111.
- Row sync: row passes through a 2-flop synchronizer (row_s) that runs every cycle, including while scan_en=0.
- Divider:
  - When scan_en=1, cnt increments each cycle.
  - tick = (cnt == SCAN_DIV-1); on tick, cnt wraps to 0.
- Column state (col_idx 0..3, acting as a 4-state FSM COL0->COL1->COL2->COL3->COL0, advancing on tick):
  - col = ~(4'b0001 << col_idx) while scan_en=1.
  - Change takes effect on the cycle after tick.
- Sampling:
  - On tick, frame_buf[col_idx*4 +: 4] <= row_s.
  - SCAN_DIV >= 4 guarantees row_s reflects the currently driven column (2-cycle sync plus settle).
- Frame commit, on tick with col_idx==3:
  - key_n <= {row_s, frame_buf[11:0]}.
  - frame_done=1 for exactly that following cycle.
  - any_key and key_code are registered from the new key_n value in the same cycle as key_n (computed from the next value, so they are aligned with key_n, not lagging it).
- Latency: a press stable for a full frame appears in key_n within 8*SCAN_DIV+3 cycles worst case.
- key_code priority: lowest index wins. Example: keys 5 and 9 both pressed -> key_code=5.
- key_n changes only at a frame commit; it is stable between commits.
- scan_en=0:
  - Next cycle: cnt=0, col_idx=0, col=4'b1111.
  - No sampling and no frame_done.
  - key_n, any_key and key_code hold their last committed values.
  - The partially filled frame_buf is discarded; it is overwritten on restart.
- scan_en 0->1: scanning restarts at COL0 with cnt=0; the first commit occurs 4*SCAN_DIV cycles later.
- Reset mid-frame: all state returns to reset values on that edge, and no frame_done is generated.
- Simultaneous tick and scan_en falling: scan_en=0 wins; no sample and no commit.

Optional Feature:
- Macro: KEYPAD_GHOST_BLOCK_EN.
- Defined:
  - At commit, if the candidate frame has 3 or more pressed keys (zeros), key_n, any_key and key_code hold their previous values.
  - ghost=1 until the next commit.
  - frame_done still pulses.
  - If the candidate frame has 2 or fewer pressed keys, it commits normally and ghost=0.
- Not defined: every frame commits unconditionally, and ghost is tied to 0.

Test Plan (SCAN_DIV=4 unless stated):
- Reset held 3 cycles, then released with scan_en=1 and row=4'hF:
  - col sequence 1110,1101,1011,0111 repeating, 4 cycles each.
  - frame_done every 16 cycles.
  - key_n=16'hFFFF, any_key=0.
- Model a press at col 2/row 1 (row[1]=0 only while col[2]=0), held 40 cycles:
  - key_n=16'hFDFF (bit 9 low), any_key=1, key_code=9.
  - Release: key_n returns to 16'hFFFF within 2 frames.
- Press keys 5 and 14 together: key_n=16'hBFDF, key_code=5.
- Drop scan_en mid-COL2 for 10 cycles:
  - col=4'b1111, key_n unchanged, no frame_done.
  - On re-enable, col=4'b1110 first and the first frame_done comes 16 cycles later.
- Assert rst=0 for one cycle during COL3 with key 0 pressed: all outputs return to reset values, and no frame_done occurs on that edge.
- With KEYPAD_GHOST_BLOCK_EN, press keys 0, 1, 4:
  - key_n holds its prior 16'hFFFF and ghost=1.
  - Release key 4: key_n=16'hFFFC, ghost=0.
